i2f_pipe: RTL and testbench

//  Pipelined, parametrised integer-to-float converter for the RV32F datapath (FCVT.S.W/WU successor).

---
 rtl/i2f_pkg.sv | 27 ++
 rtl/i2f_lzc.sv | 25 ++
 rtl/i2f_pipe.sv | 186 ++++++++++++++++++
 tb/tb_i2f_pipe.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2f_pkg.sv
// Shared constants for the integer-to-float converter: rounding-mode
// encodings, fflags bit positions and the canonical quiet-NaN pattern.
package i2f_pkg;

   localparam logic [2:0] RM_RNE = 3'b000;
   localparam logic [2:0] RM_RTZ = 3'b001;
   localparam logic [2:0] RM_RDN = 3'b010;
   localparam logic [2:0] RM_RUP = 3'b011;
   localparam logic [2:0] RM_RMM = 3'b100;

   // Bit positions inside the 5-bit {NV,DZ,OF,UF,NX} flag vector
   localparam int FLAG_NV = 4;
   localparam int FLAG_DZ = 3;
   localparam int FLAG_OF = 2;
   localparam int FLAG_UF = 1;
   localparam int FLAG_NX = 0;

   // Canonical quiet NaN {0, all-ones exponent, 1, zeros}, right-aligned in
   // a 64-bit word so callers can slice it to their own format width.
   function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
      logic [63:0] r;
      r = ((64'd1 << exp_w) - 64'd1) << man_w;
      r = r | (64'd1 << (man_w - 1));
      return r;
   endfunction

endpackage

// File: rtl/i2f_lzc.sv
// Combinational leading-zero counter. An all-zero input reports W.
module i2f_lzc #(
   parameter int W = 32
) (
   input  logic [W-1:0]        a,
   output logic [$clog2(W):0]  cnt
);

   localparam int CW = $clog2(W) + 1;

   logic seen;

   // Scan from the MSB down; every position above the first one counts.
   always_comb begin
      seen = 1'b0;
      cnt  = '0;
      for (int i = W - 1; i >= 0; i--) begin
         seen = seen | a[i];
         if (!seen) begin
            cnt = cnt + CW'(1);
         end
      end
   end

endmodule

// File: rtl/i2f_pipe.sv
// Three-stage integer-to-float converter with valid/ready on both sides.
// S1: sign/magnitude, S2: normalise, S3: round, pack and raise fflags.
module i2f_pipe
   import i2f_pkg::*;
#(
   parameter int INT_W = 32,
   parameter int EXP_W = 8,
   parameter int MAN_W = 23
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [INT_W-1:0]         in_int,
   input  logic                     in_signed,
   input  logic [2:0]               in_rm,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [EXP_W+MAN_W:0]     out_fp,
   output logic [4:0]               out_flags
);

   localparam int FP_W = 1 + EXP_W + MAN_W;
   localparam int LZ_W = $clog2(INT_W) + 1;
   // Exponent arithmetic width: holds INT_W-1 + bias + carry without wrap
   localparam int EW   = ((EXP_W > LZ_W) ? EXP_W : LZ_W) + 2;
   // Normalised magnitude padded so guard and sticky always exist
   localparam int GX_W = INT_W + MAN_W + 2;

   localparam logic [EW-1:0]    BIAS    = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic [EW-1:0]    EXP_MAX = EW'((1 << EXP_W) - 1);
   localparam logic [EW-1:0]    TOP_E   = EW'(INT_W - 1);
   localparam logic [INT_W-1:0] ONE_I   = INT_W'(1);
   localparam logic [63:0]      NAN64   = canon_nan(EXP_W, MAN_W);

   logic en;

   // Stage 1 state
   logic             v1_reg;
   logic             sign1_reg;
   logic [INT_W-1:0] mag1_reg;
   logic [2:0]       rm1_reg;
   logic             sign1_next;
   logic [INT_W-1:0] mag1_next;

   // Stage 2 state
   logic             v2_reg;
   logic             sign2_reg;
   logic             zero2_reg;
   logic [INT_W-1:0] norm2_reg;
   logic [EW-1:0]    exp2_reg;
   logic [2:0]       rm2_reg;
   logic [LZ_W-1:0]  lz;
   logic [INT_W-1:0] norm2_next;
   logic [EW-1:0]    exp2_next;

   // Output stage state
   logic             out_valid_reg;
   logic [FP_W-1:0]  out_fp_reg;
   logic [4:0]       out_flags_reg;
   logic [FP_W-1:0]  out_fp_next;
   logic [4:0]       out_flags_next;

   // Rounding datapath
   logic [GX_W-1:0]  ext;
   logic [MAN_W:0]   kept;
   logic             guard;
   logic             sticky;
   logic             round_up;
   logic [MAN_W+1:0] sum;
   logic             carry;
   logic [EW-1:0]    biased;
   logic             ovf;
   logic             to_inf;
   logic             unused_hidden;

   // The whole pipe moves together whenever the output slot can be freed
   assign en        = !out_valid_reg | out_ready;
   assign in_ready  = en;
   assign out_valid = out_valid_reg;
   assign out_fp    = out_fp_reg;
   assign out_flags = out_flags_reg;

   // S1 combinational: sign and magnitude (INT_MIN wraps to 2^(INT_W-1))
   always_comb begin
      sign1_next = in_signed & in_int[INT_W-1];
      mag1_next  = sign1_next ? ((~in_int) + ONE_I) : in_int;
   end

   // S1 register: capture operand sign/magnitude and rounding mode
   always_ff @(posedge clk) begin
      if (rst) begin
         v1_reg <= 1'b0;
      end else if (en) begin
         v1_reg    <= in_valid;
         sign1_reg <= sign1_next;
         mag1_reg  <= mag1_next;
         rm1_reg   <= in_rm;
      end
   end

   i2f_lzc #(.W(INT_W)) u_lzc (
      .a   (mag1_reg),
      .cnt (lz)
   );

   // S2 combinational: left-justify the magnitude and derive its exponent
   always_comb begin
      norm2_next = mag1_reg << lz;
      exp2_next  = TOP_E - EW'(lz);
   end

   // S2 register: normalised significand, unbiased exponent, zero marker
   always_ff @(posedge clk) begin
      if (rst) begin
         v2_reg <= 1'b0;
      end else if (en) begin
         v2_reg    <= v1_reg;
         sign2_reg <= sign1_reg;
         zero2_reg <= (mag1_reg == '0);
         norm2_reg <= norm2_next;
         exp2_reg  <= exp2_next;
         rm2_reg   <= rm1_reg;
      end
   end

   // S3 combinational: round, detect overflow, select special results
   always_comb begin
      ext    = {norm2_reg, {(MAN_W + 2){1'b0}}};
      kept   = ext[GX_W-1 -: MAN_W+1];
      guard  = ext[GX_W-MAN_W-2];
      sticky = |ext[GX_W-MAN_W-3:0];

      unique case (rm2_reg)
         RM_RNE:  round_up = guard & (sticky | kept[0]);
         RM_RTZ:  round_up = 1'b0;
         RM_RDN:  round_up = sign2_reg & (guard | sticky);
         RM_RUP:  round_up = !sign2_reg & (guard | sticky);
         RM_RMM:  round_up = guard;
         default: round_up = 1'b0;
      endcase

      sum           = {1'b0, kept} + {{(MAN_W + 1){1'b0}}, round_up};
      carry         = sum[MAN_W+1];
      unused_hidden = sum[MAN_W];
      biased        = exp2_reg + BIAS + {{(EW - 1){1'b0}}, carry};
      ovf           = (biased >= EXP_MAX);
      to_inf        = (rm2_reg == RM_RNE) || (rm2_reg == RM_RMM) ||
                      ((rm2_reg == RM_RUP) && !sign2_reg) ||
                      ((rm2_reg == RM_RDN) && sign2_reg);

      out_fp_next    = '0;
      out_flags_next = '0;
      if (rm2_reg > RM_RMM) begin
         out_fp_next             = NAN64[FP_W-1:0];
         out_flags_next[FLAG_NV] = 1'b1;
      end else if (zero2_reg) begin
         out_fp_next = '0;
      end else if (ovf) begin
         if (to_inf) begin
            out_fp_next = {sign2_reg, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
         end else begin
            out_fp_next = {sign2_reg, {(EXP_W - 1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
         end
         out_flags_next[FLAG_OF] = 1'b1;
         out_flags_next[FLAG_NX] = 1'b1;
      end else begin
         out_fp_next             = {sign2_reg, biased[EXP_W-1:0], sum[MAN_W-1:0]};
         out_flags_next[FLAG_NX] = guard | sticky;
      end
   end

   // Output register: holds result stable while the consumer stalls
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_reg <= 1'b0;
         out_fp_reg    <= '0;
         out_flags_reg <= '0;
      end else if (en) begin
         out_valid_reg <= v2_reg;
         out_fp_reg    <= out_fp_next;
         out_flags_reg <= out_flags_next;
      end
   end

endmodule

// File: tb/tb_i2f_pipe.sv
// Bench for i2f_pipe: single and half-like (5/10) instances driven in
// parallel, an arithmetic reference model with scoreboards, and directed
// vectors with literal expectations.
module tb_i2f_pipe;
   import i2f_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        in_valid = 1'b0;
   logic [31:0] in_int = '0;
   logic        in_signed = 1'b0;
   logic [2:0]  in_rm = '0;
   logic        out_ready = 1'b1;
   logic        in_ready, out_valid;
   logic [31:0] out_fp;
   logic [4:0]  out_flags;
   logic        in_ready_h, out_valid_h;
   logic [15:0] out_fp_h;
   logic [4:0]  out_flags_h;

   int n_checks = 0;
   int n_fail   = 0;
   int n_out    = 0;

   typedef struct {
      logic [31:0] fp;
      logic [4:0]  fl;
   } exp_t;
   exp_t q_s[$];
   exp_t q_h[$];

   i2f_pipe #(.INT_W(32), .EXP_W(8), .MAN_W(23)) dut_s (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_int(in_int), .in_signed(in_signed), .in_rm(in_rm),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_fp(out_fp), .out_flags(out_flags)
   );

   i2f_pipe #(.INT_W(32), .EXP_W(5), .MAN_W(10)) dut_h (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_h),
      .in_int(in_int), .in_signed(in_signed), .in_rm(in_rm),
      .out_valid(out_valid_h), .out_ready(out_ready),
      .out_fp(out_fp_h), .out_flags(out_flags_h)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // Reference: exact integer division of the magnitude by 2^(e-mw),
   // rounding by comparing the remainder with half an ulp.
   function automatic void model(input logic [31:0] x, input bit sg, input logic [2:0] rm,
                                 input int ew, input int mw,
                                 output logic [31:0] fp, output logic [4:0] fl);
      longint unsigned mag, q, r, half, be, emax, sbit;
      int e, sh;
      bit neg, up, to_inf;
      fp = '0;
      fl = '0;
      if (rm > 3'd4) begin
         fp = 32'((((64'd1 << ew) - 64'd1) << mw) | (64'd1 << (mw - 1)));
         fl = 5'b10000;
         return;
      end
      neg = sg && x[31];
      mag = neg ? (64'h1_0000_0000 - {32'd0, x}) : {32'd0, x};
      if (mag == 0) return;
      e = 63;
      while ((mag >> e) == 0) e--;
      if (e > mw) begin
         sh   = e - mw;
         q    = mag >> sh;
         r    = mag & ((64'd1 << sh) - 64'd1);
         half = 64'd1 << (sh - 1);
      end else begin
         q    = mag << (mw - e);
         r    = 0;
         half = 1;
      end
      case (rm)
         3'd0:    up = (r > half) || ((r == half) && q[0]);
         3'd1:    up = 1'b0;
         3'd2:    up = neg && (r != 0);
         3'd3:    up = !neg && (r != 0);
         default: up = (r >= half);
      endcase
      q = q + (up ? 64'd1 : 64'd0);
      if ((q >> (mw + 1)) != 0) begin
         q = q >> 1;
         e++;
      end
      be   = 64'(e) + (64'd1 << (ew - 1)) - 64'd1;
      emax = (64'd1 << ew) - 64'd1;
      sbit = neg ? (64'd1 << (ew + mw)) : 64'd0;
      if (be >= emax) begin
         to_inf = (rm == 3'd0) || (rm == 3'd4) || ((rm == 3'd3) && !neg) || ((rm == 3'd2) && neg);
         fp = 32'(sbit | (to_inf ? (emax << mw)
                                 : (((emax - 64'd1) << mw) | ((64'd1 << mw) - 64'd1))));
         fl = 5'b00101;
      end else begin
         fp = 32'(sbit | (be << mw) | (q & ((64'd1 << mw) - 64'd1)));
         fl = {4'b0, r != 0};
      end
   endfunction

   // Monitor/compare: scoreboard every transfer, handshake law, stall stability
   logic        prev_stall = 1'b0;
   logic [31:0] prev_fp;
   logic [4:0]  prev_fl;
   always @(negedge clk) begin
      exp_t es, eh;
      logic [31:0] mfp;
      logic [4:0]  mfl;
      if (rst) begin
         q_s.delete();
         q_h.delete();
         prev_stall = 1'b0;
      end else begin
         chk("in_ready_law", {31'd0, in_ready}, {31'd0, !out_valid | out_ready});
         if (in_valid && in_ready) begin
            model(in_int, in_signed, in_rm, 8, 23, mfp, mfl);
            es.fp = mfp; es.fl = mfl; q_s.push_back(es);
            model(in_int, in_signed, in_rm, 5, 10, mfp, mfl);
            eh.fp = mfp; eh.fl = mfl; q_h.push_back(eh);
         end
         if (prev_stall) begin
            chk("stall_valid", {31'd0, out_valid}, 32'd1);
            chk("stall_fp", out_fp, prev_fp);
            chk("stall_flags", {27'd0, out_flags}, {27'd0, prev_fl});
         end
         if (out_valid && out_ready) begin
            n_out++;
            $display("out #%0d fp=%h flags=%b | half fp=%h flags=%b",
                     n_out, out_fp, out_flags, out_fp_h, out_flags_h);
            if (q_s.size() == 0) begin
               chk("unexpected_output", {31'd0, out_valid}, 32'd0);
            end else begin
               es = q_s.pop_front();
               chk("sb_fp", out_fp, es.fp);
               chk("sb_flags", {27'd0, out_flags}, {27'd0, es.fl});
            end
            if (q_h.size() == 0 || !out_valid_h) begin
               chk("h_unexpected_or_missing", {31'd0, out_valid_h}, {31'd0, q_h.size() != 0});
               if (q_h.size() != 0) void'(q_h.pop_front());
            end else begin
               eh = q_h.pop_front();
               chk("h_sb_fp", {16'd0, out_fp_h}, eh.fp);
               chk("h_sb_flags", {27'd0, out_flags_h}, {27'd0, eh.fl});
            end
         end
         prev_stall = out_valid && !out_ready;
         prev_fp    = out_fp;
         prev_fl    = out_flags;
      end
   end

   // One operand with out_ready high; checks model, latency and literal result
   task automatic direct(input string name, input logic [31:0] x, input bit sg,
                         input logic [2:0] rm, input bit half,
                         input logic [31:0] efp, input logic [4:0] efl);
      logic [31:0] mfp;
      logic [4:0]  mfl;
      model(x, sg, rm, half ? 5 : 8, half ? 10 : 23, mfp, mfl);
      chk({name, "_model_fp"}, mfp, efp);
      chk({name, "_model_flags"}, {27'd0, mfl}, {27'd0, efl});
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; in_int = x; in_signed = sg; in_rm = rm;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #1;
      chk({name, "_early_valid"}, {31'd0, out_valid}, 32'd0);
      @(posedge clk); #1;
      if (half) begin
         chk({name, "_valid"}, {31'd0, out_valid_h}, 32'd1);
         chk({name, "_fp"}, {16'd0, out_fp_h}, efp);
         chk({name, "_flags"}, {27'd0, out_flags_h}, {27'd0, efl});
      end else begin
         chk({name, "_valid"}, {31'd0, out_valid}, 32'd1);
         chk({name, "_fp"}, out_fp, efp);
         chk({name, "_flags"}, {27'd0, out_flags}, {27'd0, efl});
      end
   endtask

   logic [31:0] s_int[8];
   bit          s_sg[8];
   logic [2:0]  s_rm[8];

   initial begin
      int idx;
      int cyc;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_fp", out_fp, 32'd0);
      chk("rst_out_flags", {27'd0, out_flags}, 32'd0);
      chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
      rst = 1'b0;

      // Directed single-precision vectors
      direct("pos16",    32'h0000_0010, 1'b1, RM_RNE, 1'b0, 32'h4180_0000, 5'b00000);
      direct("neg16",    32'hFFFF_FFF0, 1'b1, RM_RNE, 1'b0, 32'hC180_0000, 5'b00000);
      direct("intmin",   32'h8000_0000, 1'b1, RM_RNE, 1'b0, 32'hCF00_0000, 5'b00000);
      direct("zero",     32'h0000_0000, 1'b1, RM_RNE, 1'b0, 32'h0000_0000, 5'b00000);
      direct("zero_rdn", 32'h0000_0000, 1'b1, RM_RDN, 1'b0, 32'h0000_0000, 5'b00000);
      direct("p29_rne",  32'h1FFF_FFFF, 1'b1, RM_RNE, 1'b0, 32'h4E00_0000, 5'b00001);
      direct("p29_rtz",  32'h1FFF_FFFF, 1'b1, RM_RTZ, 1'b0, 32'h4DFF_FFFF, 5'b00001);
      direct("u_rne",    32'hFFFF_FFF0, 1'b0, RM_RNE, 1'b0, 32'h4F80_0000, 5'b00001);
      direct("u_rtz",    32'hFFFF_FFF0, 1'b0, RM_RTZ, 1'b0, 32'h4F7F_FFFF, 5'b00001);
      direct("n29_rdn",  32'hE000_0001, 1'b1, RM_RDN, 1'b0, 32'hCE00_0000, 5'b00001);
      direct("n29_rup",  32'hE000_0001, 1'b1, RM_RUP, 1'b0, 32'hCDFF_FFFF, 5'b00001);
      direct("tie_rne",  32'h0100_0001, 1'b0, RM_RNE, 1'b0, 32'h4B80_0000, 5'b00001);
      direct("tie_rmm",  32'h0100_0001, 1'b0, RM_RMM, 1'b0, 32'h4B80_0001, 5'b00001);
      direct("nan",      32'h1234_5678, 1'b1, 3'b101, 1'b0, 32'h7FC0_0000, 5'b10000);

      // Directed 5/10 format vectors (overflow policy, NaN, normal)
      direct("h_16",      32'h0000_0010, 1'b0, RM_RNE, 1'b1, 32'h0000_4C00, 5'b00000);
      direct("h_ovf_rne", 32'd70000,     1'b0, RM_RNE, 1'b1, 32'h0000_7C00, 5'b00101);
      direct("h_ovf_rtz", 32'd70000,     1'b0, RM_RTZ, 1'b1, 32'h0000_7BFF, 5'b00101);
      direct("h_ovf_rdn", 32'd70000,     1'b0, RM_RDN, 1'b1, 32'h0000_7BFF, 5'b00101);
      direct("h_novf_rdn",32'hFFFE_EE90, 1'b1, RM_RDN, 1'b1, 32'h0000_FC00, 5'b00101);
      direct("h_nan",     32'h0000_0005, 1'b0, 3'b111, 1'b1, 32'h0000_7E00, 5'b10000);

      // Back-to-back stream with random back-pressure
      s_int = '{32'd7, 32'hFFFF_FFF9, 32'h00FF_FFFF, 32'h7FFF_FFFF,
                32'h7FFF_FFFF, 32'h1234_5678, 32'h8000_0001, 32'hFFFF_FFFF};
      s_sg  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      s_rm  = '{RM_RNE, RM_RUP, RM_RMM, RM_RNE, RM_RTZ, RM_RMM, RM_RUP, RM_RDN};
      idx = 0;
      cyc = 0;
      while (cyc < 400 && (idx < 8 || q_s.size() != 0)) begin
         @(posedge clk); #1;
         out_ready = ($urandom_range(0, 1) == 1);
         if (idx < 8) begin
            in_valid = 1'b1; in_int = s_int[idx]; in_signed = s_sg[idx]; in_rm = s_rm[idx];
         end else begin
            in_valid = 1'b0;
         end
         @(negedge clk);
         if (in_valid && in_ready) idx++;
         cyc++;
      end
      chk("stream_accepted", idx, 32'd8);
      chk("stream_drained", q_s.size(), 32'd0);

      // Reset with two operands in flight
      @(posedge clk); #1;
      out_ready = 1'b1; in_valid = 1'b1; in_int = 32'd100; in_signed = 1'b0; in_rm = RM_RNE;
      @(posedge clk); #1;
      in_int = 32'd200;
      @(posedge clk); #1;
      in_valid = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_flush_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_flush_ready", {31'd0, in_ready}, 32'd1);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         chk("no_stale", {31'd0, out_valid}, 32'd0);
      end
      direct("post_rst", 32'h0000_0003, 1'b0, RM_RNE, 1'b0, 32'h4040_0000, 5'b00000);

      repeat (3) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
